// File: rtl/mips20_pkg.sv
// Shared processor definitions: datapath widths, the NOP encoding and the
// state encoding of the IF/ID pipeline register.
package mips20_pkg;

  localparam int unsigned PcWidth    = 20;
  localparam int unsigned InstrWidth = 20;

  localparam logic [InstrWidth-1:0] NopInstr = 20'h00000;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } if_id_state_e;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: a main register driving decode plus one skid entry,
// so in_ready depends only on registered state and never on out_ready.
module if_id_pipe_reg
  import mips20_pkg::*;
#(
  parameter int unsigned        PC_W      = PcWidth,
  parameter int unsigned        INSTR_W   = InstrWidth,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NopInstr)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  if_id_state_e       state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic accept;
  logic release_en;

  assign out_valid  = (state_q != StEmpty);
  assign in_ready   = (state_q != StFull);
  assign accept     = in_valid && in_ready;
  assign release_en = out_valid && out_ready;

  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d      = StBusy;
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end
      end
      StBusy: begin
        if (accept && release_en) begin
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end else if (release_en) begin
          // Main keeps the released pair so decode sees stable data while empty.
          state_d = StEmpty;
        end else if (accept) begin
          state_d      = StFull;
          skid_pc_d    = in_pc;
          skid_instr_d = in_instr;
        end
      end
      StFull: begin
        if (release_en) begin
          state_d      = StBusy;
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Redirect wins over any transfer in the same cycle.
    if (flush) begin
      state_d      = StEmpty;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed vector table, hand-written corner sequences
// and a random run against a two-entry queue model.
module tb_if_id_pipe_reg;

  localparam logic [19:0] Nop = 20'h00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_pc;
  logic [19:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_pc;
  logic [19:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_pipe_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [19:0] pc;
    logic [19:0] instr;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [19:0] epc;
    logic [19:0] einstr;
  } vec_t;

  typedef struct packed {
    logic [19:0] pc;
    logic [19:0] instr;
  } pair_t;

  vec_t  tbl[12];
  pair_t q[$];
  pair_t last;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic er,
                         input logic [19:0] epc, input logic [19:0] einstr);
    cmp({tag, "/out_valid"}, 32'(out_valid), 32'(ev));
    cmp({tag, "/in_ready"},  32'(in_ready),  32'(er));
    cmp({tag, "/out_pc"},    32'(out_pc),    32'(epc));
    cmp({tag, "/out_instr"}, 32'(out_instr), 32'(einstr));
  endtask

  task automatic drive(input logic iv, input logic [19:0] pc, input logic [19:0] instr,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic step(input logic iv, input logic [19:0] pc, input logic [19:0] instr,
                      input logic fl, input logic ordy);
    drive(iv, pc, instr, fl, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 20'h0, 20'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // iv  pc        instr      fl    ordy  ev    er    epc       einstr
    tbl[0]  = '{1'b1, 20'd5,  20'hA0005, 1'b0, 1'b0, 1'b1, 1'b1, 20'd5,  20'hA0005};
    tbl[1]  = '{1'b1, 20'd6,  20'hA0006, 1'b0, 1'b0, 1'b1, 1'b0, 20'd5,  20'hA0005};
    tbl[2]  = '{1'b1, 20'd7,  20'hA0007, 1'b0, 1'b0, 1'b1, 1'b0, 20'd5,  20'hA0005};
    tbl[3]  = '{1'b0, 20'd0,  20'h00000, 1'b0, 1'b1, 1'b1, 1'b1, 20'd6,  20'hA0006};
    tbl[4]  = '{1'b0, 20'd0,  20'h00000, 1'b0, 1'b1, 1'b0, 1'b1, 20'd6,  20'hA0006};
    tbl[5]  = '{1'b1, 20'd3,  20'hA0003, 1'b0, 1'b1, 1'b1, 1'b1, 20'd3,  20'hA0003};
    tbl[6]  = '{1'b0, 20'd0,  20'h00000, 1'b0, 1'b1, 1'b0, 1'b1, 20'd3,  20'hA0003};
    tbl[7]  = '{1'b1, 20'd8,  20'hA0008, 1'b0, 1'b0, 1'b1, 1'b1, 20'd8,  20'hA0008};
    tbl[8]  = '{1'b1, 20'd9,  20'hA0009, 1'b0, 1'b1, 1'b1, 1'b1, 20'd9,  20'hA0009};
    tbl[9]  = '{1'b1, 20'd10, 20'hA000A, 1'b0, 1'b0, 1'b1, 1'b0, 20'd9,  20'hA0009};
    tbl[10] = '{1'b1, 20'd11, 20'hA000B, 1'b1, 1'b1, 1'b0, 1'b1, 20'd0,  Nop};
    tbl[11] = '{1'b0, 20'd0,  20'h00000, 1'b0, 1'b1, 1'b0, 1'b1, 20'd0,  Nop};

    // Reset values are visible before any clock edge.
    rst_n = 1'b0;
    drive(1'b0, 20'h0, 20'h0, 1'b0, 1'b0);
    #2;
    chk_out("reset_t0", 1'b0, 1'b1, 20'd0, Nop);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: fill, stall, skid, drain, pass-through, flush priority.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].fl, tbl[i].ordy);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].epc, tbl[i].einstr);
    end

    // Back-to-back streaming with decode always ready: no bubbles.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 20'(i), 20'hA0000 | 20'(i), 1'b0, 1'b1);
      chk_out($sformatf("stream%0d", i), 1'b1, 1'b1, 20'(i), 20'hA0000 | 20'(i));
    end
    step(1'b0, 20'd0, 20'd0, 1'b0, 1'b1);
    chk_out("stream_drain", 1'b0, 1'b1, 20'd8, 20'hA0008);

    // Asynchronous reset while FULL, then first post-reset edge accepts.
    step(1'b1, 20'd5, 20'hA0005, 1'b0, 1'b0);
    step(1'b1, 20'd6, 20'hA0006, 1'b0, 1'b0);
    chk_out("pre_reset_full", 1'b1, 1'b0, 20'd5, 20'hA0005);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 1'b1, 20'd0, Nop);
    drive(1'b0, 20'd0, 20'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 20'h00077, 20'hB0077, 1'b0, 1'b0);
    chk_out("post_reset_accept", 1'b1, 1'b1, 20'h00077, 20'hB0077);

    // Random traffic against a capacity-two FIFO model.
    do_reset();
    q.delete();
    last = '{pc: 20'd0, instr: Nop};
    for (int i = 0; i < 10000; i++) begin
      logic        iv, fl, ordy, acc, rel;
      logic [19:0] pc, instr;
      pair_t       shown;
      iv    = 1'($urandom_range(0, 1));
      pc    = 20'($urandom);
      instr = 20'($urandom);
      fl    = ($urandom_range(0, 99) < 5);
      ordy  = ($urandom_range(0, 3) != 0);
      acc   = iv && (q.size() < 2);
      rel   = (q.size() > 0) && ordy;
      step(iv, pc, instr, fl, ordy);
      if (fl) begin
        q.delete();
        last = '{pc: 20'd0, instr: Nop};
      end else begin
        if (rel) last = q.pop_front();
        if (acc) q.push_back('{pc: pc, instr: instr});
      end
      shown = (q.size() > 0) ? q[0] : last;
      chk_out($sformatf("rand%0d", i), q.size() > 0, q.size() < 2, shown.pc, shown.instr);
      if (n_fail > 20) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

Interface
REQ-001 SHALL have parameter PC_W, default 20, width of the program-counter path.
REQ-002 SHALL have parameter INSTR_W, default 20, width of the instruction path.
REQ-003 SHALL have parameter NOP_INSTR, default 20'h00000, instruction value presented after reset or flush.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream (fetch) holds a valid PC+1/instruction pair.
REQ-007 SHALL have port in_ready  output  1  block can accept a pair this cycle.
REQ-008 SHALL have port in_pc  input  PC_W  incremented PC from fetch.
REQ-009 SHALL have port in_instr  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port flush  input  1  kill all held entries (branch/jump redirect).
REQ-011 SHALL have port out_valid  output  1  out_pc/out_instr hold a valid entry.
REQ-012 SHALL have port out_ready  input  1  decode accepts the entry; low = stall.
REQ-013 SHALL have port out_pc  output  PC_W  registered incremented PC to decode.
REQ-014 SHALL have port out_instr  output  INSTR_W  registered instruction to decode.

Function
REQ-015 SHALL accept a pair only when in_valid && in_ready; release only when out_valid && out_ready.
REQ-016 SHALL hold a main register (drives outputs) and one skid register; FSM states EMPTY, BUSY (main full), FULL (main+skid full).
REQ-017 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both from registered state only, so no combinational path exists from out_ready to in_ready.
REQ-018 EMPTY: accept -> BUSY, main <= in; no accept -> stay.
REQ-019 BUSY: accept+release -> BUSY, main <= in; release only -> EMPTY; accept only -> FULL, skid <= in; neither -> stay.
REQ-020 FULL: release -> BUSY, main <= skid; no release -> stay; no accept possible.
REQ-021 SHALL provide latency of exactly 1 cycle from accept to out_valid when entering EMPTY->BUSY, and sustain one transfer per cycle while out_ready stays high.
REQ-022 SHALL keep out_pc/out_instr stable while out_valid && !out_ready (stall), and SHALL preserve order: the skid entry never overtakes the main entry.
REQ-023 SHALL on flush force next state EMPTY, main_instr <= NOP_INSTR, main_pc <= 0; flush has priority over any simultaneous accept or release, and a pair accepted in the flush cycle is discarded.
REQ-024 SHALL retain the last released data on out_pc/out_instr when draining to EMPTY without flush.
REQ-025 SHALL pass PC and instruction unmodified; no arithmetic on either path.

Reset
REQ-026 SHALL on rst_n low immediately set state EMPTY, out_valid 0, in_ready 1, out_pc 0, out_instr NOP_INSTR, skid contents 0, independent of clk.
REQ-027 SHALL discard any in-flight entry on reset mid-operation and accept new input on the first rising clk after rst_n deasserts.

Structure
REQ-028 SHALL place the FSM state encoding (EMPTY/BUSY/FULL), default widths (20) and NOP_INSTR default in the shared processor package mips20_pkg.
REQ-029 SHALL be a single module with no sub-module; the skid logic is internal.

Verification
REQ-030 Reset: rst_n low mid-stream with FULL state -> out_valid 0, in_ready 1, out_instr 20'h00000 without a clock edge.
REQ-031 Streaming: out_ready=1, push pc 1..8 with instr 20'hA0001..20'hA0008 back-to-back -> same pairs appear in order, one cycle later each, no bubbles.
REQ-032 Stall/skid: push pc=5 and pc=6, hold out_ready=0 -> state FULL, in_ready 0, out_pc=5 stable; raise out_ready -> 5 then 6 released, in_ready 1 after first release.
REQ-033 Flush priority: FULL state, in_valid=1 with pc=9, flush=1 and out_ready=1 same cycle -> next cycle out_valid 0, out_instr NOP, pc=9 never appears.
REQ-034 Drain: single pair pc=3 accepted, out_ready=1, no further input -> out_valid low after release, out_pc stays 3.
REQ-035 Random: random in_valid/out_ready/flush (flush 5%) 10k cycles against a queue model -> no loss, duplication or reordering between flushes.
